// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the header-insert arbiter and the AXI-Stream header inserter.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_EOP = 2'd2
    } state_t;

    function automatic int unsigned idx_wd(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of element i in a flattened vector of w-bit elements.
    function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
        return i * w;
    endfunction

endpackage

// File: rtl/axis_hdr_insert_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import axis_hdr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_WD  = idx_wd(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_WD-1:0]  ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_WD-1:0]  idx,
    output logic               any
);

    logic              found;
    logic [IDX_WD-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_WD'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axis_hdr_insert_arbiter.sv
// Round-robin arbiter sharing the inserter's header port; grant held from header accept to packet end.
module axis_hdr_insert_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned IDX_WD       = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            hdr_valid,
    output logic [DATA_WD-1:0]              hdr_data,
    output logic [DATA_BYTE_WD-1:0]         hdr_keep,
    output logic [BYTE_CNT_WD-1:0]          hdr_byte_cnt,
    input  logic                            hdr_ready,
    input  logic                            pkt_last_fire,
    output logic [IDX_WD-1:0]               grant_idx,
    output logic                            grant_active,
    output logic                            err_stray,
    output logic                            err_timeout
);

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t                  state_q, state_d;
    logic [IDX_WD-1:0]       ptr_q, ptr_d;
    logic [IDX_WD-1:0]       grant_idx_q, grant_idx_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
    logic [BYTE_CNT_WD-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0]             wdog_q, wdog_d;
    logic                    err_stray_q, err_stray_d;
    logic                    err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]      win_gnt;
    logic [IDX_WD-1:0]       win_idx;
    logic                    win_any;
    logic [DATA_WD-1:0]      sel_data;
    logic [DATA_BYTE_WD-1:0] sel_keep;
    logic [BYTE_CNT_WD-1:0]  sel_cnt;
    logic                    wd_expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_WD  (IDX_WD)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_cnt  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_WD'(i)) begin
                sel_data = req_data[slice_lo(i, DATA_WD) +: DATA_WD];
                sel_keep = req_keep[slice_lo(i, DATA_BYTE_WD) +: DATA_BYTE_WD];
                sel_cnt  = req_byte_cnt[slice_lo(i, BYTE_CNT_WD) +: BYTE_CNT_WD];
            end
        end
    end

    assign wd_expire = (TIMEOUT_CYC != 0) && (wdog_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        hdr_valid_d   = hdr_valid_q;
        hdr_data_d    = hdr_data_q;
        hdr_keep_d    = hdr_keep_q;
        hdr_cnt_d     = hdr_cnt_q;
        wdog_d        = wdog_q;
        err_stray_d   = err_stray_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            IDLE: begin
                if (pkt_last_fire) err_stray_d = 1'b1;
                if (win_any) begin
                    hdr_data_d  = sel_data;
                    hdr_keep_d  = sel_keep;
                    hdr_cnt_d   = sel_cnt;
                    grant_idx_d = win_idx;
                    hdr_valid_d = 1'b1;
                    state_d     = OFFER;
                end
            end
            OFFER: begin
                if (pkt_last_fire) err_stray_d = 1'b1;
                if (hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    wdog_d      = '0;
                    state_d     = WAIT_EOP;
                end
            end
            WAIT_EOP: begin
                wdog_d = wdog_q + 16'd1;
                // A real packet end in the expiry cycle wins over the watchdog.
                if (pkt_last_fire || wd_expire) begin
                    ptr_d   = grant_idx_q;
                    wdog_d  = '0;
                    state_d = IDLE;
                    if (!pkt_last_fire) err_timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_WD'(NUM_REQ - 1);
            grant_idx_q   <= '0;
            hdr_valid_q   <= 1'b0;
            hdr_data_q    <= '0;
            hdr_keep_q    <= '0;
            hdr_cnt_q     <= '0;
            wdog_q        <= '0;
            err_stray_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            hdr_valid_q   <= hdr_valid_d;
            hdr_data_q    <= hdr_data_d;
            hdr_keep_q    <= hdr_keep_d;
            hdr_cnt_q     <= hdr_cnt_d;
            wdog_q        <= wdog_d;
            err_stray_q   <= err_stray_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready    = (state_q == IDLE && !rst) ? win_gnt : '0;
    assign hdr_valid    = hdr_valid_q;
    assign hdr_data     = hdr_data_q;
    assign hdr_keep     = hdr_keep_q;
    assign hdr_byte_cnt = hdr_cnt_q;
    assign grant_idx    = grant_idx_q;
    assign grant_active = (state_q != IDLE);
    assign err_stray    = err_stray_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Directed bench for axis_hdr_insert_arbiter with a header scoreboard and a reference round-robin model.
module tb_axis_hdr_insert_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*KW-1:0] req_keep;
    logic [N*CW-1:0] req_byte_cnt;
    logic [N-1:0]    req_ready;
    logic            hdr_valid;
    logic [DW-1:0]   hdr_data;
    logic [KW-1:0]   hdr_keep;
    logic [CW-1:0]   hdr_byte_cnt;
    logic            hdr_ready;
    logic            pkt_last_fire;
    logic [IW-1:0]   grant_idx;
    logic            grant_active;
    logic            err_stray;
    logic            err_timeout;

    always #5 clk = ~clk;

    axis_hdr_insert_arbiter #(
        .NUM_REQ     (N),
        .DATA_WD     (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_keep      (req_keep),
        .req_byte_cnt  (req_byte_cnt),
        .req_ready     (req_ready),
        .hdr_valid     (hdr_valid),
        .hdr_data      (hdr_data),
        .hdr_keep      (hdr_keep),
        .hdr_byte_cnt  (hdr_byte_cnt),
        .hdr_ready     (hdr_ready),
        .pkt_last_fire (pkt_last_fire),
        .grant_idx     (grant_idx),
        .grant_active  (grant_active),
        .err_stray     (err_stray),
        .err_timeout   (err_timeout)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned m_ptr;
    int          cur_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int unsigned i = 1; i <= N; i++) begin
            if (mask[(m_ptr + i) % N]) return int'((m_ptr + i) % N);
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = N - 1;
        sb.delete();
    endtask

    // Grant a header from vmask, hold hdr_ready low for `hold` cycles, then accept it.
    task automatic grant(input logic [N-1:0] vmask, input int unsigned hold, input string tag);
        int   w;
        exp_t e;
        w = model_pick(vmask);
        e.idx  = IW'(w);
        e.data = req_data[w*DW +: DW];
        e.keep = req_keep[w*KW +: KW];
        e.cnt  = req_byte_cnt[w*CW +: CW];
        sb.push_back(e);
        req_valid = vmask;
        #1;
        chk({tag, "_req_ready"}, req_ready, 32'(1 << w));
        tick();
        for (int unsigned k = 0; k < hold; k++) begin
            chk({tag, "_offer_valid"}, hdr_valid, 1);
            chk({tag, "_offer_data"}, hdr_data, e.data);
            chk({tag, "_offer_rdy0"}, req_ready, 0);
            tick();
        end
        hdr_ready = 1'b1;
        #1;
        e = sb.pop_front();
        chk({tag, "_hdr_valid"}, hdr_valid, 1);
        chk({tag, "_grant_idx"}, grant_idx, e.idx);
        chk({tag, "_hdr_data"}, hdr_data, e.data);
        chk({tag, "_hdr_keep"}, hdr_keep, e.keep);
        chk({tag, "_hdr_cnt"}, hdr_byte_cnt, e.cnt);
        chk({tag, "_active"}, grant_active, 1);
        tick();
        hdr_ready = 1'b0;
        req_valid = '0;
        #1;
        chk({tag, "_valid_drop"}, hdr_valid, 0);
        chk({tag, "_wait_active"}, grant_active, 1);
        cur_w = w;
    endtask

    task automatic finish_pkt(input int unsigned nwait, input string tag);
        repeat (nwait) tick();
        pkt_last_fire = 1'b1;
        tick();
        pkt_last_fire = 1'b0;
        #1;
        chk({tag, "_released"}, grant_active, 0);
        m_ptr = cur_w;
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 4'b1111;
        hdr_ready     = 1'b0;
        pkt_last_fire = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            req_data[i*DW +: DW]     = 32'hA5A5_0001 + 32'(i);
            req_keep[i*KW +: KW]     = 4'hF >> i;
            req_byte_cnt[i*CW +: CW] = CW'(3 - i);
        end
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_active", grant_active, 0);
        req_valid = '0;
        rst = 1'b0;
        m_ptr = N - 1;
        #1;
        chk("post_rst_hdr_valid", hdr_valid, 0);
        chk("post_rst_hdr_data", hdr_data, 0);
        chk("post_rst_grant_idx", grant_idx, 0);
        chk("post_rst_active", grant_active, 0);
        chk("post_rst_err_stray", err_stray, 0);
        chk("post_rst_err_timeout", err_timeout, 0);
        chk("post_rst_req_ready", req_ready, 0);

        // All sources valid: rotation 0,1,2,3,0,1,2,3
        for (int p = 0; p < 8; p++) begin
            grant(4'b1111, 0, "rr");
            chk("rr_order", grant_idx, 32'(p % 4));
            finish_pkt(p % 3, "rr");
        end

        // Back-pressure in OFFER: source 0 header held stable
        grant(4'b1111, 5, "hold");
        chk("hold_src0", grant_idx, 0);
        finish_pkt(1, "hold");

        // Single requester granted every packet
        grant(4'b0100, 0, "single_a");
        chk("single_a_idx", grant_idx, 2);
        finish_pkt(0, "single_a");
        grant(4'b0100, 0, "single_b");
        chk("single_b_idx", grant_idx, 2);
        finish_pkt(2, "single_b");

        // Watchdog: no packet end, forced release after 8 cycles
        grant(4'b1111, 0, "wd");
        chk("wd_idx", grant_idx, 3);
        repeat (7) tick();
        chk("wd_still_active", grant_active, 1);
        chk("wd_not_yet", err_timeout, 0);
        tick();
        chk("wd_released", grant_active, 0);
        chk("wd_err_timeout", err_timeout, 1);
        m_ptr = cur_w;
        grant(4'b1111, 0, "wd_next");
        chk("wd_next_idx", grant_idx, 0);
        finish_pkt(0, "wd_next");

        // Stray packet end in IDLE
        chk("stray_pre", err_stray, 0);
        pkt_last_fire = 1'b1;
        tick();
        pkt_last_fire = 1'b0;
        #1;
        chk("stray_err", err_stray, 1);
        chk("stray_idle", grant_active, 0);
        chk("stray_hdr_valid", hdr_valid, 0);

        // Packet end coincident with watchdog expiry
        do_reset();
        #1;
        chk("coin_rst_stray", err_stray, 0);
        chk("coin_rst_timeout", err_timeout, 0);
        grant(4'b1111, 0, "coin");
        chk("coin_idx", grant_idx, 0);
        finish_pkt(7, "coin");
        chk("coin_no_timeout", err_timeout, 0);
        chk("coin_no_stray", err_stray, 0);

        // Reset during WAIT_EOP
        grant(4'b1111, 0, "midrst");
        chk("midrst_idx", grant_idx, 1);
        tick();
        tick();
        do_reset();
        #1;
        chk("midrst_idle", grant_active, 0);
        chk("midrst_hdr_valid", hdr_valid, 0);
        chk("midrst_grant_idx", grant_idx, 0);
        grant(4'b1111, 0, "after_rst");
        chk("after_rst_idx", grant_idx, 0);
        finish_pkt(0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
